// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer: FSM states, output modes,
// symbol payload layout and element timing in units.
package morse_pkg;

  localparam int unsigned LEN_W          = 3;
  localparam int unsigned PAT_W          = 6;
  localparam int unsigned SYM_W          = LEN_W + PAT_W;
  localparam int unsigned DASH_UNITS     = 3;
  localparam int unsigned CHAR_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS = 4;
  localparam int unsigned MAX_ELEM       = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MARK,
    ST_SPACE,
    ST_WGAP
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_CW      = 2'b01,
    MODE_MCW     = 2'b10,
    MODE_CARRIER = 2'b11
  } mode_e;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pattern;
  } sym_t;

  // A length of 7 cannot be sent with a 6-bit pattern, so clamp it.
  function automatic logic [LEN_W-1:0] elem_count(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_ELEM)) ? LEN_W'(MAX_ELEM) : len;
  endfunction

endpackage

// File: rtl/morse_keyer_am_if.sv
// Symbol push channel into the keyer (valid/ready handshake).
interface morse_keyer_am_if;

  logic            sym_valid;
  logic            sym_ready;
  morse_pkg::sym_t sym_data;

  modport master (output sym_valid, output sym_data, input sym_ready);
  modport slave  (input sym_valid, input sym_data, output sym_ready);

endinterface

// File: rtl/morse_sym_fifo.sv
// Synchronous symbol queue; o_ready is a registered not-full flag.
module morse_sym_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_empty_c,
  output logic             o_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty_c = (r_count == '0);
  assign o_rdata_c = r_mem[r_rd];
  assign w_wr_en   = i_push & o_ready & ~i_flush;
  assign w_rd_en   = i_pop & ~o_empty_c & ~i_flush;

  always_comb begin
    w_count_nxt = r_count + (AW+1)'(w_wr_en) - (AW+1)'(w_rd_en);
    if (i_flush) w_count_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      o_ready <= 1'b0;
    end else begin
      r_wr    <= i_flush ? '0 : r_wr + AW'(w_wr_en);
      r_rd    <= i_flush ? '0 : r_rd + AW'(w_rd_en);
      r_count <= w_count_nxt;
      o_ready <= (w_count_nxt != (AW+1)'(DEPTH));
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= i_wdata;
  end

endmodule

// File: rtl/morse_keyer_am.sv
// Morse keyer: queued symbols are keyed as dot/dash/gap intervals and the
// key drives an RF gate directly, tone-modulated or as a test carrier.
module morse_keyer_am
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_W     = 24,
  parameter int unsigned TONE_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              sys_clk,
  input  logic              ck_rst,
  input  logic [UNIT_W-1:0] unit_len,
  input  logic [TONE_W-1:0] tone_half,
  input  logic [1:0]        mode,
  input  logic              flush,
  morse_keyer_am_if.slave   sym_if,
  output logic              key,
  output logic              gate,
  output logic              tone,
  output logic              busy
);

  localparam int unsigned CNT_W = UNIT_W + 2;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  w_pat_nxt;
  logic [LEN_W-1:0]  r_rem;
  logic [LEN_W-1:0]  w_rem_nxt;
  logic [CNT_W-1:0]  w_unit;
  logic [SYM_W-1:0]  w_head_bits;
  sym_t              w_head;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [TONE_W-1:0] r_tone_cnt;
  logic [TONE_W-1:0] w_tone_cnt_nxt;
  logic              r_tone;
  logic              w_tone_nxt;
  logic              r_key;
  logic              w_key_nxt;
  logic              r_gate;
  logic              w_gate_nxt;
  logic              r_busy;
  logic              w_busy_nxt;

  assign w_unit = (unit_len == '0) ? CNT_W'(1) : CNT_W'(unit_len);
  assign w_head = sym_t'(w_head_bits);
  assign w_push = sym_if.sym_valid & sym_if.sym_ready & ~flush;
  assign w_pop  = (r_state == ST_LOAD) & ~flush;

  // Interval length minus one, sampled from the live unit length.
  function automatic logic [CNT_W-1:0] span(input logic [2:0] units, input logic [CNT_W-1:0] u);
    return CNT_W'(units) * u - CNT_W'(1);
  endfunction

  morse_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYM_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (ck_rst),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_wdata   (sym_if.sym_data),
    .i_pop     (w_pop),
    .o_rdata_c (w_head_bits),
    .o_empty_c (w_empty),
    .o_ready   (sym_if.sym_ready)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pat_nxt   = r_pat;
    w_rem_nxt   = r_rem;
    unique case (r_state)
      ST_IDLE: if (!w_empty) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_pat_nxt = w_head.pattern;
        w_rem_nxt = elem_count(w_head.len);
        if (w_head.len == '0) begin
          w_state_nxt = ST_WGAP;
          w_cnt_nxt   = span(3'(WORD_GAP_UNITS), w_unit);
        end else begin
          w_state_nxt = ST_MARK;
          w_cnt_nxt   = span(w_head.pattern[0] ? 3'(DASH_UNITS) : 3'd1, w_unit);
        end
      end
      ST_MARK: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = ST_SPACE;
          w_pat_nxt   = r_pat >> 1;
          w_rem_nxt   = r_rem - LEN_W'(1);
          w_cnt_nxt   = span((r_rem == LEN_W'(1)) ? 3'(CHAR_GAP_UNITS) : 3'd1, w_unit);
        end
      end
      ST_SPACE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (r_rem != '0) begin
          w_state_nxt = ST_MARK;
          w_cnt_nxt   = span(r_pat[0] ? 3'(DASH_UNITS) : 3'd1, w_unit);
        end else begin
          // Go straight to LOAD so queued characters follow without an idle cycle.
          w_state_nxt = w_empty ? ST_IDLE : ST_LOAD;
        end
      end
      ST_WGAP: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        else             w_state_nxt = w_empty ? ST_IDLE : ST_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge ck_rst) begin
    if (!ck_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pat   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pat   <= w_pat_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Free-running tone; >= keeps the wrap safe if tone_half drops mid-count.
  always_comb begin
    w_tone_cnt_nxt = r_tone_cnt + TONE_W'(1);
    w_tone_nxt     = r_tone;
    if (tone_half == '0) begin
      w_tone_cnt_nxt = '0;
      w_tone_nxt     = 1'b1;
    end else if (r_tone_cnt >= tone_half - TONE_W'(1)) begin
      w_tone_cnt_nxt = '0;
      w_tone_nxt     = ~r_tone;
    end
  end

  assign w_key_nxt  = (r_state == ST_MARK) & ~flush;
  assign w_busy_nxt = ~flush & ((r_state != ST_IDLE) | ~w_empty | w_push);

  // Gate is built from next-cycle key/tone so it stays aligned with them.
  always_comb begin
    w_gate_nxt = 1'b0;
    unique case (mode_e'(mode))
      MODE_OFF:     w_gate_nxt = 1'b0;
      MODE_CW:      w_gate_nxt = w_key_nxt;
      MODE_MCW:     w_gate_nxt = w_key_nxt & w_tone_nxt;
      MODE_CARRIER: w_gate_nxt = 1'b1;
      default:      w_gate_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge ck_rst) begin
    if (!ck_rst) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
      r_key      <= 1'b0;
      r_gate     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tone_cnt <= w_tone_cnt_nxt;
      r_tone     <= w_tone_nxt;
      r_key      <= w_key_nxt;
      r_gate     <= w_gate_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign key  = r_key;
  assign gate = r_gate;
  assign tone = r_tone;
  assign busy = r_busy;

endmodule

// File: tb/tb_morse_keyer_am.sv
// Directed and randomised checks of morse_keyer_am against a cycle-trace
// model built from Morse timing rules (units per mark/gap, one LOAD cycle).
module tb_morse_keyer_am;
  import morse_pkg::*;

  localparam int unsigned UNIT_W = 24;
  localparam int unsigned TONE_W = 16;
  localparam int unsigned DEPTH  = 4;

  logic              sys_clk;
  logic              ck_rst;
  logic [UNIT_W-1:0] unit_len;
  logic [TONE_W-1:0] tone_half;
  logic [1:0]        mode;
  logic              flush;
  logic              key;
  logic              gate;
  logic              tone;
  logic              busy;

  morse_keyer_am_if sym_if();

  morse_keyer_am #(
    .UNIT_W     (UNIT_W),
    .TONE_W     (TONE_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk   (sys_clk),
    .ck_rst    (ck_rst),
    .unit_len  (unit_len),
    .tone_half (tone_half),
    .mode      (mode),
    .flush     (flush),
    .sym_if    (sym_if),
    .key       (key),
    .gate      (gate),
    .tone      (tone),
    .busy      (busy)
  );

  int         n_chk;
  int         n_fail;
  int         n_edge;
  logic [8:0] seq[$];
  bit         exp_key[$];
  int         acc;
  int         ns;
  bit         seen;
  bit         r_smp;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Edges since reset release, for the tone model.
  always @(posedge sys_clk or negedge ck_rst) begin
    if (!ck_rst) n_edge <= 0;
    else         n_edge <= n_edge + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit tone_model();
    int h;
    h = int'(tone_half);
    if (h == 0) return (n_edge >= 1);
    return ((n_edge / h) % 2) == 1;
  endfunction

  // Expected key per sample, sample 0 taken just after the first push edge.
  function automatic void build_trace(input int u);
    int uu;
    int len;
    uu = (u == 0) ? 1 : u;
    exp_key = {};
    repeat (3) exp_key.push_back(1'b0);
    foreach (seq[i]) begin
      len = int'(seq[i][8:6]);
      if (len == 7) len = 6;
      if (i > 0) exp_key.push_back(1'b0);
      if (len == 0) begin
        repeat (4 * uu) exp_key.push_back(1'b0);
      end else begin
        for (int e = 0; e < len; e++) begin
          repeat ((seq[i][e] ? 3 : 1) * uu) exp_key.push_back(1'b1);
          repeat (((e == len - 1) ? 3 : 1) * uu) exp_key.push_back(1'b0);
        end
      end
    end
  endfunction

  task automatic run_seq(input int u, input logic [1:0] md, input int extra, input string tag);
    bit   ek;
    bit   et;
    logic eg;
    int   n;
    unit_len = UNIT_W'(u);
    mode     = md;
    build_trace(u);
    n = exp_key.size();
    for (int j = 0; j < n + extra; j++) begin
      if (j < seq.size()) begin
        chk({tag, "_ready"}, 32'(sym_if.sym_ready), 32'd1);
        sym_if.sym_valid = 1'b1;
        sym_if.sym_data  = sym_t'(seq[j]);
      end else begin
        sym_if.sym_valid = 1'b0;
      end
      @(posedge sys_clk);
      #1;
      ek = (j < n) ? exp_key[j] : 1'b0;
      et = tone_model();
      case (md)
        2'd0:    eg = 1'b0;
        2'd1:    eg = ek;
        2'd2:    eg = ek & et;
        default: eg = 1'b1;
      endcase
      chk({tag, "_key"},  32'(key),  32'(ek));
      chk({tag, "_busy"}, 32'(busy), 32'(j < n));
      chk({tag, "_gate"}, 32'(gate), 32'(eg));
      chk({tag, "_tone"}, 32'(tone), 32'(et));
    end
  endtask

  initial begin
    n_chk            = 0;
    n_fail           = 0;
    ck_rst           = 1'b0;
    flush            = 1'b0;
    mode             = 2'd1;
    unit_len         = UNIT_W'(4);
    tone_half        = TONE_W'(3);
    sym_if.sym_valid = 1'b0;
    sym_if.sym_data  = '0;

    #11;
    chk("rst_key",   32'(key),   32'd0);
    chk("rst_gate",  32'(gate),  32'd0);
    chk("rst_tone",  32'(tone),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_ready", 32'(sym_if.sym_ready), 32'd0);
    #1 ck_rst = 1'b1;
    #1;
    chk("ready_before_edge", 32'(sym_if.sym_ready), 32'd0);
    @(posedge sys_clk);
    #1;
    chk("ready_first_edge", 32'(sym_if.sym_ready), 32'd1);
    repeat (3) @(posedge sys_clk);
    #1;

    seq = {9'b010_000010};
    run_seq(4, 2'd1, 4, "letter_A");

    seq = {9'b001_000000, 9'b000_000000, 9'b001_000001};
    run_seq(2, 2'd1, 4, "E_space_T");

    seq = {9'b001_000001, 9'b001_000001};
    run_seq(2, 2'd2, 4, "mcw_dash");

    seq = {9'b011_000101};
    run_seq(1, 2'd3, 4, "carrier");

    seq = {9'b100_001100};
    run_seq(3, 2'd0, 4, "mode_off");

    seq = {9'b111_101010};
    run_seq(0, 2'd1, 4, "len7_unit0");

    repeat (8) begin
      ns  = $urandom_range(1, 4);
      seq = {};
      for (int i = 0; i < ns; i++) seq.push_back(9'($urandom));
      run_seq($urandom_range(0, 3), 2'($urandom_range(0, 3)), 4, "rand");
    end

    // Back-pressure: five accepts fill FSM plus a 4-deep queue.
    unit_len         = UNIT_W'(100);
    mode             = 2'd1;
    acc              = 0;
    sym_if.sym_valid = 1'b1;
    sym_if.sym_data  = sym_t'(9'b001_000000);
    for (int c = 0; c < 20 && acc < 5; c++) begin
      r_smp = sym_if.sym_ready;
      @(posedge sys_clk);
      #1;
      if (r_smp) acc++;
    end
    chk("full_accepts", 32'(acc), 32'd5);
    chk("full_ready_low", 32'(sym_if.sym_ready), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge sys_clk);
      #1;
      if (sym_if.sym_ready) seen = 1'b1;
    end
    chk("sixth_held", 32'(seen), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge sys_clk);
      #1;
      if (sym_if.sym_ready) seen = 1'b1;
    end
    chk("ready_after_pop", 32'(seen), 32'd1);
    @(posedge sys_clk);
    #1;
    sym_if.sym_valid = 1'b0;
    chk("sixth_accepted_full", 32'(sym_if.sym_ready), 32'd0);

    flush = 1'b1;
    @(posedge sys_clk);
    #1;
    flush = 1'b0;
    chk("flush1_busy",  32'(busy), 32'd0);
    chk("flush1_ready", 32'(sym_if.sym_ready), 32'd1);
    chk("flush1_key",   32'(key),  32'd0);
    repeat (2) @(posedge sys_clk);
    #1;

    // Flush with three queued and a push in the same cycle.
    sym_if.sym_data = sym_t'(9'b001_000001);
    for (int j = 0; j < 4; j++) begin
      sym_if.sym_valid = 1'b1;
      @(posedge sys_clk);
      #1;
    end
    chk("pre_flush_key", 32'(key), 32'd1);
    flush           = 1'b1;
    sym_if.sym_data = sym_t'(9'b010_000011);
    @(posedge sys_clk);
    #1;
    flush            = 1'b0;
    sym_if.sym_valid = 1'b0;
    chk("flush2_key",   32'(key),  32'd0);
    chk("flush2_gate",  32'(gate), 32'd0);
    chk("flush2_busy",  32'(busy), 32'd0);
    chk("flush2_ready", 32'(sym_if.sym_ready), 32'd1);
    seen = 1'b0;
    repeat (10) begin
      @(posedge sys_clk);
      #1;
      if (key || busy) seen = 1'b1;
    end
    chk("flush2_dropped", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of a dash.
    unit_len         = UNIT_W'(10);
    sym_if.sym_valid = 1'b1;
    sym_if.sym_data  = sym_t'(9'b001_000001);
    @(posedge sys_clk);
    #1;
    sym_if.sym_valid = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    chk("mid_dash_key",  32'(key),  32'd1);
    chk("mid_dash_gate", 32'(gate), 32'd1);
    #1 ck_rst = 1'b0;
    #1;
    chk("arst_key",   32'(key),  32'd0);
    chk("arst_gate",  32'(gate), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_tone",  32'(tone), 32'd0);
    chk("arst_ready", 32'(sym_if.sym_ready), 32'd0);
    repeat (5) @(posedge sys_clk);
    #2 ck_rst = 1'b1;
    chk("rel_ready_pre", 32'(sym_if.sym_ready), 32'd0);
    @(posedge sys_clk);
    #1;
    chk("rel_ready", 32'(sym_if.sym_ready), 32'd1);
    chk("rel_busy",  32'(busy), 32'd0);
    chk("rel_key",   32'(key),  32'd0);
    repeat (2) @(posedge sys_clk);
    #1;

    // tone_half = 0 holds the tone high, so MCW gate follows key.
    ck_rst    = 1'b0;
    tone_half = '0;
    #3 ck_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    seq = {9'b010_000010};
    run_seq(1, 2'd2, 4, "tone_held");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
